// File: rtl/regfile_dbg_port.sv
// regfile_dbg_port: debug-host initiator for the 16x16 register file.
// Serialises read/write/dump commands behind a hold_req/hold_ack ownership handshake.
module regfile_dbg_port #(
   parameter int NREGS  = 16,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic              rsp_err,
   output logic              hold_req,
   input  logic              hold_ack,
   output logic              rf_regwrite,
   output logic [ADDR_W-1:0] rf_ra1,
   output logic [ADDR_W-1:0] rf_ra2,
   output logic [DATA_W-1:0] rf_wd,
   input  logic [DATA_W-1:0] rf_rd1
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   localparam logic [1:0]        OP_READ   = 2'b00;
   localparam logic [1:0]        OP_WRITE  = 2'b01;
   localparam logic [1:0]        OP_DUMP   = 2'b10;
   localparam logic [1:0]        OP_RSVD   = 2'b11;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

   state_t            state_r;
   logic [1:0]        op_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] data_r;
   logic              cmd_ready_r;
   logic              hold_req_r;
   logic              rsp_valid_r;
   logic              rsp_last_r;
   logic              rsp_err_r;
   logic [ADDR_W-1:0] rsp_addr_r;
   logic [DATA_W-1:0] rsp_data_r;
   logic              access_s;
   logic              is_last_s;

   // The register file is only touched while we own it and are in ACCESS.
   assign access_s  = (state_r == ST_ACCESS) && hold_ack;
   assign is_last_s = (op_r != OP_DUMP) || (addr_r == LAST_ADDR);

   // Command sequencer: state, latched command and registered handshake/response outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         op_r        <= OP_READ;
         addr_r      <= '0;
         data_r      <= '0;
         cmd_ready_r <= 1'b0;
         hold_req_r  <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_last_r  <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_addr_r  <= '0;
         rsp_data_r  <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               cmd_ready_r <= 1'b1;
               if (cmd_valid && cmd_ready_r) begin
                  cmd_ready_r <= 1'b0;
                  op_r        <= cmd_op;
                  data_r      <= cmd_data;
                  addr_r      <= (cmd_op == OP_DUMP) ? '0 : cmd_addr;
                  if (cmd_op == OP_RSVD) begin
                     // Rejected without ever asking the core for the register file.
                     state_r     <= ST_RESP;
                     rsp_valid_r <= 1'b1;
                     rsp_err_r   <= 1'b1;
                     rsp_last_r  <= 1'b1;
                     rsp_addr_r  <= cmd_addr;
                     rsp_data_r  <= '0;
                  end else begin
                     state_r    <= ST_REQ;
                     hold_req_r <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               if (hold_ack) begin
                  state_r <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (hold_ack) begin
                  state_r     <= ST_RESP;
                  rsp_valid_r <= 1'b1;
                  rsp_err_r   <= 1'b0;
                  rsp_last_r  <= is_last_s;
                  rsp_addr_r  <= addr_r;
                  rsp_data_r  <= (op_r == OP_WRITE) ? data_r :
                                 ((addr_r == '0) ? '0 : rf_rd1);
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  if (rsp_last_r) begin
                     state_r     <= ST_IDLE;
                     hold_req_r  <= 1'b0;
                     cmd_ready_r <= 1'b1;
                  end else begin
                     // Next dump register: ownership is kept, so skip REQ.
                     addr_r  <= addr_r + ADDR_W'(1);
                     state_r <= ST_ACCESS;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Register-file port drive; everything parks at zero unless we are accessing.
   always_comb begin
      rf_regwrite = 1'b0;
      rf_ra1      = '0;
      rf_ra2      = '0;
      rf_wd       = '0;
      if (access_s) begin
         if (op_r == OP_WRITE) begin
            rf_regwrite = 1'b1;
            rf_ra2      = addr_r;
            rf_wd       = data_r;
         end else begin
            rf_ra1 = addr_r;
         end
      end else begin
         rf_regwrite = 1'b0;
      end
   end

   assign cmd_ready = cmd_ready_r;
   assign hold_req  = hold_req_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_last  = rsp_last_r;
   assign rsp_err   = rsp_err_r;
   assign rsp_addr  = rsp_addr_r;
   assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_regfile_dbg_port.sv
// tb_regfile_dbg_port: directed vectors plus hand sequences for regfile_dbg_port,
// with a small register-file model behind the rf_* ports.
module tb_regfile_dbg_port;

   localparam logic [1:0] OP_RD   = 2'b00;
   localparam logic [1:0] OP_WR   = 2'b01;
   localparam logic [1:0] OP_DUMP = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [3:0]  cmd_addr;
   logic [15:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [3:0]  rsp_addr;
   logic [15:0] rsp_data;
   logic        rsp_last;
   logic        rsp_err;
   logic        hold_req;
   logic        hold_ack;
   logic        rf_regwrite;
   logic [3:0]  rf_ra1;
   logic [3:0]  rf_ra2;
   logic [15:0] rf_wd;
   logic [15:0] rf_rd1;

   logic [15:0] regs [16] = '{default: 16'h0000};
   int          cyc    = 0;
   int          wr_cnt = 0;
   int          checks   = 0;
   int          failures = 0;
   int          t0 = 0;

   typedef struct packed {
      logic [1:0]  op;
      logic [3:0]  addr;
      logic [15:0] data;
      logic [3:0]  e_addr;
      logic [15:0] e_data;
      logic        e_last;
      logic        e_err;
      logic        e_hold;
   } vec_t;

   vec_t vecs [10];

   regfile_dbg_port #(.NREGS(16), .ADDR_W(4), .DATA_W(16)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
      .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
      .hold_req(hold_req), .hold_ack(hold_ack),
      .rf_regwrite(rf_regwrite), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
      .rf_wd(rf_wd), .rf_rd1(rf_rd1)
   );

   always #5 clk = ~clk;

   // Register file model: reg 0 hardwired to zero, write on posedge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rf_regwrite) begin
         wr_cnt <= wr_cnt + 1;
         if (rf_ra2 != 4'd0) regs[rf_ra2] <= rf_wd;
      end
   end
   assign rf_rd1 = (rf_ra1 == 4'd0) ? 16'h0000 : regs[rf_ra1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accept cycle.
   task automatic send_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [15:0] data);
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      t0        = cyc;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_data  = data;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_addr  = 4'd0;
      cmd_data  = 16'h0000;
   endtask

   task automatic wait_rsp(output bit seen_hold);
      int n = 0;
      seen_hold = hold_req;
      while (rsp_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
         seen_hold = seen_hold | hold_req;
      end
      check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      bit sh;
      send_cmd(v.op, v.addr, v.data);
      wait_rsp(sh);
      check($sformatf("%s_addr", tag), 32'(rsp_addr), 32'(v.e_addr));
      check($sformatf("%s_data", tag), 32'(rsp_data), 32'(v.e_data));
      check($sformatf("%s_last", tag), 32'(rsp_last), 32'(v.e_last));
      check($sformatf("%s_err", tag),  32'(rsp_err),  32'(v.e_err));
      check($sformatf("%s_hold", tag), 32'(sh),       32'(v.e_hold));
      @(negedge clk);
      check($sformatf("%s_rsp_drop", tag), 32'(rsp_valid), 32'd0);
      check($sformatf("%s_hold_rel", tag), 32'(hold_req),  32'd0);
   endtask

   initial begin
      vec_t v;
      bit   sh;
      int   n;
      int   w0;
      int   hold_drop;

      //          op       addr   data      e_addr e_data    last  err   hold
      vecs[0] = '{OP_RD,   4'd5,  16'h0000, 4'd5,  16'h0505, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{OP_RD,   4'd0,  16'h0000, 4'd0,  16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{OP_WR,   4'd0,  16'h5A5A, 4'd0,  16'h5A5A, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{OP_RD,   4'd0,  16'h0000, 4'd0,  16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{OP_RSVD, 4'd9,  16'h1111, 4'd9,  16'h0000, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{OP_WR,   4'd15, 16'h0001, 4'd15, 16'h0001, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{OP_RD,   4'd15, 16'h0000, 4'd15, 16'h0001, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{OP_RD,   4'd3,  16'h0000, 4'd3,  16'h0303, 1'b1, 1'b0, 1'b1};
      vecs[8] = '{OP_WR,   4'd15, 16'h0F0F, 4'd15, 16'h0F0F, 1'b1, 1'b0, 1'b1};
      vecs[9] = '{OP_RD,   4'd10, 16'h0000, 4'd10, 16'h0A0A, 1'b1, 1'b0, 1'b1};

      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 4'd0; cmd_data = 16'h0000;
      rsp_ready = 1'b1; hold_ack = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready),   32'd0);
      check("rst_hold_req",  32'(hold_req),    32'd0);
      check("rst_rsp_valid", 32'(rsp_valid),   32'd0);
      check("rst_rsp_data",  32'(rsp_data),    32'd0);
      check("rst_rsp_err",   32'(rsp_err),     32'd0);
      check("rst_regwrite",  32'(rf_regwrite), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      check("idle_ra1", 32'(rf_ra1), 32'd0);
      check("idle_ra2", 32'(rf_ra2), 32'd0);
      check("idle_wd",  32'(rf_wd),  32'd0);

      // Write r3=BEEF, cycle by cycle.
      w0 = wr_cnt;
      send_cmd(OP_WR, 4'd3, 16'hBEEF);
      check("wr_c1_hold",  32'(hold_req),    32'd1);
      check("wr_c1_ready", 32'(cmd_ready),   32'd0);
      check("wr_c1_we",    32'(rf_regwrite), 32'd0);
      @(negedge clk);
      check("wr_c2_we",    32'(rf_regwrite), 32'd1);
      check("wr_c2_ra2",   32'(rf_ra2),      32'd3);
      check("wr_c2_wd",    32'(rf_wd),       32'hBEEF);
      check("wr_c2_rspv",  32'(rsp_valid),   32'd0);
      @(negedge clk);
      check("wr_c3_rspv",  32'(rsp_valid),   32'd1);
      check("wr_c3_addr",  32'(rsp_addr),    32'd3);
      check("wr_c3_data",  32'(rsp_data),    32'hBEEF);
      check("wr_c3_last",  32'(rsp_last),    32'd1);
      check("wr_c3_we",    32'(rf_regwrite), 32'd0);
      @(negedge clk);
      check("wr_c4_ready", 32'(cmd_ready),   32'd1);
      check("wr_c4_hold",  32'(hold_req),    32'd0);
      check("wr_latency",  32'(cyc - t0),    32'd4);
      check("wr_pulses",   32'(wr_cnt - w0), 32'd1);

      // Preload r[i] = i*0101 through the DUT.
      for (int i = 1; i < 16; i++) begin
         v = '{OP_WR, 4'(i), 16'(i) * 16'h0101, 4'(i), 16'(i) * 16'h0101, 1'b1, 1'b0, 1'b1};
         run_vec(v, $sformatf("pre%0d", i));
      end

      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Full dump.
      hold_drop = 0;
      send_cmd(OP_DUMP, 4'd7, 16'h0000);
      for (int i = 0; i < 16; i++) begin
         n = 0;
         while (rsp_valid !== 1'b1 && n < 20) begin
            if (hold_req !== 1'b1) hold_drop++;
            @(negedge clk);
            n++;
         end
         check($sformatf("dump%0d_valid", i), 32'(rsp_valid), 32'd1);
         check($sformatf("dump%0d_addr", i),  32'(rsp_addr),  32'(i));
         check($sformatf("dump%0d_data", i),  32'(rsp_data),  32'(16'(i) * 16'h0101));
         check($sformatf("dump%0d_last", i),  32'(rsp_last),  32'(i == 15));
         if (hold_req !== 1'b1) hold_drop++;
         @(negedge clk);
      end
      check("dump_hold_cont", 32'(hold_drop), 32'd0);
      check("dump_idle",      32'(cmd_ready), 32'd1);
      check("dump_hold_rel",  32'(hold_req),  32'd0);
      check("dump_latency",   32'(cyc - t0),  32'd34);

      // Read with response back-pressure.
      v = '{OP_WR, 4'd5, 16'h1234, 4'd5, 16'h1234, 1'b1, 1'b0, 1'b1};
      run_vec(v, "wr5");
      rsp_ready = 1'b0;
      send_cmd(OP_RD, 4'd5, 16'h0000);
      wait_rsp(sh);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'd1);
         check($sformatf("bp%0d_data", k),  32'(rsp_data),  32'h1234);
         check($sformatf("bp%0d_ready", k), 32'(cmd_ready), 32'd0);
         @(negedge clk);
      end
      check("bp_still_valid", 32'(rsp_valid), 32'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_idle_ready", 32'(cmd_ready), 32'd1);
      check("bp_idle_rspv",  32'(rsp_valid), 32'd0);

      // Read while the core withholds the register file.
      hold_ack = 1'b0;
      w0 = wr_cnt;
      send_cmd(OP_RD, 4'd5, 16'h0000);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("nack%0d_hold", k), 32'(hold_req),    32'd1);
         check($sformatf("nack%0d_rspv", k), 32'(rsp_valid),   32'd0);
         check($sformatf("nack%0d_ra1", k),  32'(rf_ra1),      32'd0);
         check($sformatf("nack%0d_we", k),   32'(rf_regwrite), 32'd0);
         @(negedge clk);
      end
      hold_ack = 1'b1;
      @(negedge clk);
      check("ack_access_ra1", 32'(rf_ra1),    32'd5);
      check("ack_access_rspv", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("ack_rsp_valid", 32'(rsp_valid),   32'd1);
      check("ack_rsp_data",  32'(rsp_data),    32'h1234);
      check("ack_no_write",  32'(wr_cnt - w0), 32'd0);
      @(negedge clk);

      // Reset in the middle of a dump.
      send_cmd(OP_DUMP, 4'd0, 16'h0000);
      n = 0;
      while (!(rsp_valid === 1'b1 && rsp_addr == 4'd7) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("mid_reach7", 32'(rsp_addr), 32'd7);
      reset = 1'b1;
      @(negedge clk);
      check("mid_hold",  32'(hold_req),    32'd0);
      check("mid_rspv",  32'(rsp_valid),   32'd0);
      check("mid_we",    32'(rf_regwrite), 32'd0);
      check("mid_ready", 32'(cmd_ready),   32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      v = '{OP_RD, 4'd2, 16'h0000, 4'd2, 16'h0202, 1'b1, 1'b0, 1'b1};
      run_vec(v, "post_rst_rd2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

endmodule

// File: doc/regfile_dbg_port.md
# regfile_dbg_port

Debug-side initiator for the processor's 16x16 register file. It accepts host commands over a valid/ready port: single-register read, single-register write, or a full dump of all 16 registers. It requests exclusive register-file access from the core with a hold request/acknowledge pair, then drives the register file's write and read ports. Every read result and every write acknowledge is returned on a valid/ready response stream. It sits between the debug host link and the register-file write/read mux in the datapath.

## Interface
- NREGS, 16, number of registers scanned by a dump
- ADDR_W, 4, register address width
- DATA_W, 16, register data width
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 read, 01 write, 10 dump, 11 reserved
- cmd_addr  in  ADDR_W  target register (read/write)
- cmd_data  in  DATA_W  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_addr  out  ADDR_W  register the response refers to
- rsp_data  out  DATA_W  read data, or echoed write data
- rsp_last  out  1  final response of the command
- rsp_err  out  1  reserved opcode
- hold_req  out  1  request core to stall register-file access
- hold_ack  in  1  core has stalled; block owns register file
- rf_regwrite  out  1  register-file write enable
- rf_ra1  out  ADDR_W  register-file read address 1
- rf_ra2  out  ADDR_W  register-file read/write address 2
- rf_wd  out  DATA_W  register-file write data
- rf_rd1  in  DATA_W  register-file read data 1 (combinational, reg 0 reads 0)

## Operation
- States: IDLE, REQ, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch op/addr/data.
  - Reserved op: go to RESP with rsp_err=1, rsp_data=0, rsp_last=1. hold_req is never raised.
  - Any other op: go to REQ.
  - For a dump, the latched address is reset to 0.
- REQ: hold_req=1. Go to ACCESS on the first cycle hold_ack=1.
- ACCESS: hold_req=1. All actions are gated by hold_ack; if hold_ack=0, the state is held and nothing is driven.
  - Write: rf_regwrite=1, rf_ra2=addr, rf_wd=data for exactly one cycle. Response data = data.
  - Read or dump: rf_ra1=addr; capture rf_rd1 into the response register at end of cycle.
  - Then go to RESP.
- RESP: hold_req=1 (except reserved op). rsp_valid=1; rsp_addr/rsp_data/rsp_err/rsp_last are stable until the handshake.
  - rsp_last=1 for read, write, reserved, and for dump address NREGS-1.
  - On rsp_valid&&rsp_ready:
    - If last: go to IDLE.
    - Otherwise (dump): address+1, go to ACCESS. No new REQ; hold stays asserted.
- A write to address 0 is still issued (rf_regwrite pulses). Reads of address 0 return 0.
- Dump address counter stops at NREGS-1; no wrap.
- Idle drive levels:
  - rf_regwrite=0 outside ACCESS-write with hold_ack=1.
  - rf_ra1, rf_ra2, rf_wd = 0 outside ACCESS.

## Timing
- Reset values: cmd_ready=0 during the reset cycle, then 1; all other outputs 0; state IDLE.
- Reset mid-command: abort immediately.
  - Next cycle hold_req=0, rsp_valid=0, rf_regwrite=0.
  - The pending command and the partial dump are dropped.
- Read/write latency with hold_ack already high and rsp_ready high:
  - Accept at cycle 0, REQ cycle 1, ACCESS cycle 2, RESP cycle 3 (rsp_valid), IDLE cycle 4 (cmd_ready=1).
- Dump (same conditions): 1 + 1 + 2*NREGS cycles, i.e. 34 cycles from accept to return to IDLE.
- cmd_ready=0 in every state except IDLE; no command overlap.
- rsp_valid, once high, is not dropped until the handshake.
- hold_req falls in the cycle after the last response handshake.

## Test plan
- Reset, then write op addr=3 data=16'hBEEF with hold_ack tied 1:
  - rf_regwrite pulses exactly one cycle, with rf_ra2=3 and rf_wd=BEEF.
  - Response: addr 3, data BEEF, last=1.
- Preload reg 5=16'h1234, read addr=5 with rsp_ready low for 4 cycles:
  - rsp_valid held with data 1234.
  - Handshake completes; IDLE is reached one cycle later.
- Dump with regs preloaded r[i]=i*16'h0101:
  - 16 responses, addr 0..15, data 0000, 0101, …, 0F0F (reg 0 = 0).
  - rsp_last only on addr 15; hold_req continuous across the dump.
- Issue read with hold_ack low for 5 cycles:
  - Stays in REQ, no rf_* activity.
  - Proceeds once hold_ack=1; response appears 2 cycles after the ack.
- Reserved op 11:
  - hold_req never rises.
  - Response with rsp_err=1, data 0, last=1.
- Assert reset during dump at addr 7:
  - Next cycle hold_req=0, rsp_valid=0.
  - After reset a new read of addr 2 works normally.
